// File: rtl/climate_sched_pkg.sv
// Shared types and constants for the climate request scheduler.
// Holds the FSM encoding, the pressure acceptance limit and the error sentinel.
package climate_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam logic [31:0] PRESSURE_MAX  = 32'd2047;
    localparam logic [31:0] CLIMATE_ERR   = 32'hFFFF_FFFF;
    localparam int          TIMEOUT_CNT_W = 16;

    function automatic logic pressure_in_range(input logic [31:0] press);
        return press <= PRESSURE_MAX;
    endfunction

endpackage

// File: rtl/climate_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request after i_last_grant.
// Zero latency; no backpressure of its own, the caller decides when a grant is taken.
module climate_rr_arbiter #(
    parameter int NUM_STATIONS = 4,
    parameter int ID_W         = $clog2(NUM_STATIONS)
) (
    input  logic [NUM_STATIONS-1:0] i_req,
    input  logic [ID_W-1:0]         i_last_grant,
    output logic [ID_W-1:0]         o_grant,
    output logic                    o_any_req
);

    logic [ID_W-1:0] w_idx;

    // Scan offsets 1..N so the previous winner is considered last.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_STATIONS; i++) begin
            w_idx = ID_W'((int'(i_last_grant) + i) % NUM_STATIONS);
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_grant   = w_idx;
            end
        end
    end

endmodule

// File: rtl/climate_request_scheduler.sv
// Shares one predictor core among stations: RR grant, range check, launch, timeout, tagged response.
// Accept->core_start 1 cycle, done->resp_valid 1 cycle, reject->resp_valid 1 cycle; resp held until resp_ready.
module climate_request_scheduler
    import climate_sched_pkg::*;
#(
    parameter int NUM_STATIONS   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = $clog2(NUM_STATIONS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_STATIONS-1:0]      i_st_valid,
    output logic [NUM_STATIONS-1:0]      o_st_ready,
    input  logic [NUM_STATIONS*32-1:0]   i_st_temperature,
    input  logic [NUM_STATIONS*32-1:0]   i_st_pressure,
    output logic                         o_core_start,
    output logic signed [31:0]           o_core_temperature,
    output logic [31:0]                  o_core_pressure,
    input  logic [31:0]                  i_core_condition,
    input  logic                         i_core_done,
    output logic                         o_resp_valid,
    input  logic                         i_resp_ready,
    output logic [ID_W-1:0]              o_resp_id,
    output logic [31:0]                  o_resp_condition,
    output logic                         o_resp_error,
    output logic                         o_busy,
    output logic [TIMEOUT_CNT_W-1:0]     o_timeout_count
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t             r_state;
    logic [ID_W-1:0]          r_last_grant;
    logic [ID_W-1:0]          r_id;
    logic signed [31:0]       r_temp;
    logic [31:0]              r_press;
    logic [WAIT_W-1:0]        r_wait_cnt;
    logic                     r_core_start;
    logic                     r_resp_valid;
    logic [31:0]              r_resp_cond;
    logic                     r_resp_err;
    logic [TIMEOUT_CNT_W-1:0] r_timeout_count;

    logic [ID_W-1:0]          w_grant;
    logic                     w_any_req;
    logic                     w_accept;
    logic [31:0]              w_sel_temp;
    logic [31:0]              w_sel_press;
    logic [NUM_STATIONS-1:0]  w_st_ready;

    climate_rr_arbiter #(
        .NUM_STATIONS (NUM_STATIONS),
        .ID_W         (ID_W)
    ) u_arb (
        .i_req        (i_st_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    assign w_accept = (r_state == IDLE) && w_any_req;

    always_comb begin
        w_sel_temp  = '0;
        w_sel_press = '0;
        w_st_ready  = '0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            if (ID_W'(i) == w_grant) begin
                w_sel_temp  = i_st_temperature[i*32 +: 32];
                w_sel_press = i_st_pressure[i*32 +: 32];
            end
        end
        if (w_accept) begin
            w_st_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_last_grant    <= ID_W'(NUM_STATIONS - 1);
            r_id            <= '0;
            r_temp          <= '0;
            r_press         <= '0;
            r_wait_cnt      <= '0;
            r_core_start    <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_cond     <= '0;
            r_resp_err      <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_grant;
                        r_temp  <= w_sel_temp;
                        r_press <= w_sel_press;
                        if (!pressure_in_range(w_sel_press)) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_cond  <= CLIMATE_ERR;
                        end else begin
                            r_state      <= ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // A done on the final wait cycle still counts as success.
                    if (i_core_done) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_cond  <= i_core_condition;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_cond  <= CLIMATE_ERR;
                        if (r_timeout_count != '1) begin
                            r_timeout_count <= r_timeout_count + 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_last_grant <= r_id;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_st_ready         = w_st_ready;
    assign o_core_start       = r_core_start;
    assign o_core_temperature = r_temp;
    assign o_core_pressure    = r_press;
    assign o_resp_valid       = r_resp_valid;
    assign o_resp_id          = r_id;
    assign o_resp_condition   = r_resp_cond;
    assign o_resp_error       = r_resp_err;
    assign o_busy             = (r_state != IDLE);
    assign o_timeout_count    = r_timeout_count;

endmodule
